// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter and write sequencer for a shared register
module dff_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int OWNER_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         q,
    output logic [OWNER_W-1:0]       owner,
    output logic                     busy
);

    localparam logic       IDLE   = 1'b0;
    localparam logic       LOCKED = 1'b1;
    localparam logic [OWNER_W:0]   NREQ_W = (OWNER_W+1)'(NUM_REQ);
    localparam logic [OWNER_W-1:0] LAST   = OWNER_W'(NUM_REQ - 1);

    logic               state;
    logic [OWNER_W-1:0] ptr;
    logic [OWNER_W-1:0] lock_id;

    logic [NUM_REQ-1:0] eff;
    logic               found;
    logic [OWNER_W-1:0] win;
    logic [OWNER_W:0]   cand;
    logic [OWNER_W-1:0] cand_w;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] lock_oh;
    logic [OWNER_W-1:0] ptr_next;

    // A requester acked this cycle is masked so a held req is not written twice back-to-back.
    assign eff = req & ~ack;

    always_comb begin
        found  = 1'b0;
        win    = '0;
        cand   = '0;
        cand_w = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (OWNER_W+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            cand_w = cand[OWNER_W-1:0];
            if (!found && eff[cand_w]) begin
                found = 1'b1;
                win   = cand_w;
            end
        end
    end

    assign win_oh   = NUM_REQ'(1) << win;
    assign lock_oh  = NUM_REQ'(1) << lock_id;
    assign ptr_next = (win == LAST) ? '0 : win + OWNER_W'(1);
    assign busy     = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            lock_id <= '0;
            q       <= '0;
            owner   <= '0;
            gnt     <= '0;
            ack     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        q     <= wr_data[int'(win)*WIDTH +: WIDTH];
                        owner <= win;
                        gnt   <= win_oh;
                        ack   <= win_oh;
                        ptr   <= ptr_next;
                        if (lock[win]) begin
                            state   <= LOCKED;
                            lock_id <= win;
                        end
                    end else begin
                        gnt <= '0;
                        ack <= '0;
                    end
                end
                default: begin
                    // Only the lock holder is served; a final pending write still lands on release.
                    if (eff[lock_id]) begin
                        q     <= wr_data[int'(lock_id)*WIDTH +: WIDTH];
                        owner <= lock_id;
                        ack   <= lock_oh;
                    end else begin
                        ack <= '0;
                    end
                    if (!lock[lock_id]) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end else begin
                        gnt <= lock_oh;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - directed-vector bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wr_data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    dff_bank_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wr_data(wr_data),
        .gnt(gnt), .ack(ack), .q(q), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        wr_data[i*8 +: 8] = v;
    endtask

    initial begin
        logic [7:0] cdata [4];
        cdata[0] = 8'h10; cdata[1] = 8'h21; cdata[2] = 8'h32; cdata[3] = 8'h43;

        // reset with random traffic
        reset = 1'b0; req = 4'($urandom); lock = 4'($urandom); wr_data = $urandom;
        tick(); tick();
        check("rst_q", 32'(q), 32'h00);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1; req = '0; lock = '0; wr_data = '0;
        tick();

        // single write
        req = 4'b0001; set_data(0, 8'hA5);
        tick();
        check("single_q", 32'(q), 32'hA5);
        check("single_ack", 32'(ack), 32'h1);
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        tick();
        check("single_ack_off", 32'(ack), 32'h0);
        check("single_gnt_off", 32'(gnt), 32'h0);
        check("single_q_hold", 32'(q), 32'hA5);

        // return ptr to 0 before contention
        reset = 1'b0; tick(); reset = 1'b1; tick();

        // contention: all four request, each drops on its ack
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, cdata[i]);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("cont_ack%0d", i), 32'(ack), 32'(4'b0001 << i));
            check($sformatf("cont_q%0d", i), 32'(q), 32'(cdata[i]));
            req[i] = 1'b0;
        end
        check("cont_owner", 32'(owner), 32'h3);
        tick();
        check("cont_idle_ack", 32'(ack), 32'h0);

        // fairness/wrap: serve 1 so ptr=2, then 3 beats 0
        req = 4'b0010; set_data(1, 8'h3C); lock = 4'b1000;
        tick();
        check("nonwin_lock_busy", 32'(busy), 32'h0);
        check("rr1_ack", 32'(ack), 32'h2);
        req = 4'b1001; lock = 4'b0000; set_data(0, 8'h5A); set_data(3, 8'hC3);
        tick();
        check("wrap_ack3", 32'(ack), 32'h8);
        check("wrap_q3", 32'(q), 32'hC3);
        req = 4'b0001;
        tick();
        check("wrap_ack0", 32'(ack), 32'h1);
        check("wrap_q0", 32'(q), 32'h5A);
        req = 4'b0000;
        tick();

        // lock burst by 2 while 0 waits (ptr=1)
        req = 4'b0101; lock = 4'b0100; set_data(2, 8'h11); set_data(0, 8'h99);
        tick();
        check("lk_busy0", 32'(busy), 32'h1);
        check("lk_gnt0", 32'(gnt), 32'h4);
        check("lk_ack0", 32'(ack), 32'h4);
        check("lk_q0", 32'(q), 32'h11);
        set_data(2, 8'h22);
        tick();
        check("lk_busy1", 32'(busy), 32'h1);
        check("lk_gnt1", 32'(gnt), 32'h4);
        check("lk_ack1", 32'(ack), 32'h0);
        check("lk_q1", 32'(q), 32'h11);
        tick();
        check("lk_gnt2", 32'(gnt), 32'h4);
        check("lk_ack2", 32'(ack), 32'h4);
        check("lk_q2", 32'(q), 32'h22);
        req = 4'b0001; lock = 4'b0000;
        tick();
        check("rel_busy", 32'(busy), 32'h0);
        check("rel_gnt", 32'(gnt), 32'h0);
        check("rel_ack", 32'(ack), 32'h0);
        check("rel_q", 32'(q), 32'h22);
        tick();
        check("after_ack", 32'(ack), 32'h1);
        check("after_q", 32'(q), 32'h99);
        check("after_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        tick();

        // reset mid-LOCKED
        req = 4'b0100; lock = 4'b0100; set_data(2, 8'h77);
        tick();
        check("mid_busy", 32'(busy), 32'h1);
        check("mid_q", 32'(q), 32'h77);
        req = 4'b0101; set_data(2, 8'h78); reset = 1'b0;
        tick();
        check("mid_rst_q", 32'(q), 32'h00);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ack", 32'(ack), 32'h0);
        reset = 1'b1; req = 4'b1001; lock = 4'b0000; set_data(0, 8'h5C); set_data(3, 8'hEE);
        tick();
        check("post_rst_ack", 32'(ack), 32'h1);
        check("post_rst_q", 32'(q), 32'h5C);
        check("post_rst_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
